// File: rtl/vga_pkg.sv
// vga_pkg: shared definitions for the VGA pixel fetch path.
//   PIX_BITS  - default pixel width (RGB444).
//   state_t   - fetch state: UNSYNC until the first vs rising edge, then RUN.
//   scale_ok  - true for the supported replication factors (1, 2, 4).
//   rd_lat_ok - true for the supported framebuffer read latencies (1..3).
package vga_pkg;

  localparam int PIX_BITS = 12;

  typedef enum logic {
    UNSYNC = 1'b0,
    RUN    = 1'b1
  } state_t;

  function automatic bit scale_ok(input int s);
    return (s == 1) || (s == 2) || (s == 4);
  endfunction

  function automatic bit rd_lat_ok(input int l);
    return (l >= 1) && (l <= 3);
  endfunction

endpackage

// File: rtl/vga_fetch_delay.sv
// vga_fetch_delay: tracks outstanding framebuffer reads and captures the
// returned pixel.
//   clk, rst_n - clock, asynchronous active-low reset
//   fb_en      - read issued this cycle
//   fb_data    - RAM read data, valid RD_LAT cycles after fb_en
//   pix_hold   - last captured pixel, held until the next read returns
module vga_fetch_delay #(
  parameter int RD_LAT = 1,
  parameter int PIX_W  = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fb_en,
  input  logic [PIX_W-1:0] fb_data,
  output logic [PIX_W-1:0] pix_hold
);

  // One bit per cycle of read latency; the top bit marks the cycle in which
  // fb_data belongs to the read issued RD_LAT cycles earlier.
  logic [RD_LAT-1:0] vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld      <= '0;
      pix_hold <= '0;
    end else begin
      vld <= (vld << 1) | RD_LAT'(fb_en);
      if (vld[RD_LAT-1]) begin
        pix_hold <= fb_data;
      end
    end
  end

endmodule

// File: rtl/vga_pixel_fetch.sv
// vga_pixel_fetch: turns timing-controller strobes into framebuffer reads
// with integer pixel/line replication, and drives registered RGB + syncs.
//   clk, rst_n     - clock (shared with timing), asynchronous active-low reset
//   adv            - one-cycle pixel strobe; act/hs/vs sampled only when high
//   act, hs, vs    - active-video and sync flags from timing
//   fb_en, fb_addr - framebuffer read request (combinational on the adv cycle)
//   fb_data        - read data, RD_LAT cycles after fb_en
//   rgb            - output pixel, zero whenever de_o is low
//   hs_o,vs_o,de_o - syncs / data enable delayed one pixel period
//   frame_start    - one-cycle pulse on a sampled vs rising edge
//   line_err       - sticky: an active line was not exactly HACT pixels
//
// Handshake: there is no back-pressure. A read is a single-cycle fb_en
// pulse with fb_addr; the RAM must return fb_data exactly RD_LAT cycles
// later, and RD_LAT must be shorter than the adv spacing so the pixel is
// held before the next adv registers it onto rgb.
module vga_pixel_fetch
  import vga_pkg::*;
#(
  parameter int HACT   = 640,
  parameter int VACT   = 480,
  parameter int SCALE  = 1,
  parameter int RD_LAT = 1,
  parameter int PIX_W  = PIX_BITS,
  parameter int ADDR_W = $clog2((HACT / SCALE) * (VACT / SCALE))
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              adv,
  input  logic              act,
  input  logic              hs,
  input  logic              vs,
  output logic              fb_en,
  output logic [ADDR_W-1:0] fb_addr,
  input  logic [PIX_W-1:0]  fb_data,
  output logic [PIX_W-1:0]  rgb,
  output logic              hs_o,
  output logic              vs_o,
  output logic              de_o,
  output logic              frame_start,
  output logic              line_err
);

  if (!scale_ok(SCALE)) begin : g_bad_scale
    $error("vga_pixel_fetch: SCALE must be 1, 2 or 4");
  end
  if (!rd_lat_ok(RD_LAT)) begin : g_bad_rd_lat
    $error("vga_pixel_fetch: RD_LAT must be 1..3");
  end

  localparam int HSRC      = HACT / SCALE;
  localparam int VSRC      = VACT / SCALE;
  localparam int LAST_BASE = HSRC * (VSRC - 1);
  localparam int XW        = $clog2(HACT + 1);
  localparam int SW        = 3;

  state_t state_q, state_d;

  // Timing flags sampled on the previous adv.
  logic act_s, hs_s, vs_s;
  // Previous pixel was active while running: drives de_o / rgb gating.
  logic run_act;

  logic [ADDR_W-1:0] line_base, addr, next_base;
  logic [SW-1:0]     xsub, ysub;
  logic [XW-1:0]     xcnt;

  logic running, vs_rise, eol, pix_act, xfull;
  logic [PIX_W-1:0] pix_hold;

  assign running = (state_q == RUN);
  assign vs_rise = adv & vs & ~vs_s;
  assign eol     = adv & act_s & ~act & running;
  assign pix_act = adv & act & running;
  assign xfull   = (xcnt == XW'(HACT));

  assign fb_en   = pix_act & ~xfull;
  assign fb_addr = addr;

  // The last source line is reused for any lines beyond VACT.
  assign next_base = (line_base == ADDR_W'(LAST_BASE)) ? line_base
                                                       : line_base + ADDR_W'(HSRC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= UNSYNC;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      UNSYNC:  if (vs_rise) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = UNSYNC;
    endcase
  end

  // Address and replication counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_base <= '0;
      addr      <= '0;
      xsub      <= '0;
      ysub      <= '0;
      xcnt      <= '0;
    end else if (vs_rise) begin
      line_base <= '0;
      addr      <= '0;
      xsub      <= '0;
      ysub      <= '0;
      xcnt      <= '0;
    end else if (eol) begin
      xsub <= '0;
      xcnt <= '0;
      if (ysub == SW'(SCALE - 1)) begin
        ysub      <= '0;
        line_base <= next_base;
        addr      <= next_base;
      end else begin
        ysub <= ysub + SW'(1);
        addr <= line_base;
      end
    end else if (fb_en) begin
      xcnt <= xcnt + XW'(1);
      if (xsub == SW'(SCALE - 1)) begin
        xsub <= '0;
        // Stop on the line's last source pixel so addr stays in range.
        if (xcnt != XW'(HACT - 1)) begin
          addr <= addr + ADDR_W'(1);
        end
      end else begin
        xsub <= xsub + SW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_err    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= vs_rise;
      if ((eol & ~vs_rise & ~xfull) | (pix_act & xfull)) begin
        line_err <= 1'b1;
      end
    end
  end

  vga_fetch_delay #(
    .RD_LAT (RD_LAT),
    .PIX_W  (PIX_W)
  ) u_delay (
    .clk      (clk),
    .rst_n    (rst_n),
    .fb_en    (fb_en),
    .fb_data  (fb_data),
    .pix_hold (pix_hold)
  );

  // Output stage: everything here moves only on adv.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_s   <= 1'b0;
      hs_s    <= 1'b0;
      vs_s    <= 1'b0;
      run_act <= 1'b0;
      rgb     <= '0;
      hs_o    <= 1'b0;
      vs_o    <= 1'b0;
      de_o    <= 1'b0;
    end else if (adv) begin
      act_s   <= act;
      hs_s    <= hs;
      vs_s    <= vs;
      run_act <= act & running;
      rgb     <= run_act ? pix_hold : '0;
      hs_o    <= hs_s;
      vs_o    <= vs_s;
      de_o    <= run_act;
    end
  end

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// tb_vga_pixel_fetch: two instances on one timing stream (adv every 4 clocks):
//   u_s1 - SCALE=1, RD_LAT=1
//   u_s2 - SCALE=2, RD_LAT=3
// Small HACT/VACT keep full frames short.
module tb_vga_pixel_fetch;
  timeunit 1ns;
  timeprecision 1ns;
  import vga_pkg::*;

  localparam int HACT    = 16;
  localparam int VACT    = 8;
  localparam int HBLANK  = 8;
  localparam int ADV_GAP = 4;
  localparam int A1W     = $clog2(HACT * VACT);
  localparam int A2W     = $clog2((HACT / 2) * (VACT / 2));

  logic clk, rst_n, adv, act, hs, vs;

  logic           fb_en1, fb_en2, hs_o1, hs_o2, vs_o1, vs_o2, de_o1, de_o2;
  logic           frame_start1, frame_start2, line_err1, line_err2;
  logic [A1W-1:0] fb_addr1;
  logic [A2W-1:0] fb_addr2;
  logic [11:0]    fb_data1, fb_data2, rgb1, rgb2;

  int checks, errors;

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  // ---------------- DUTs ----------------
  vga_pixel_fetch #(.HACT(HACT), .VACT(VACT), .SCALE(1), .RD_LAT(1), .PIX_W(12)) u_s1 (
    .clk(clk), .rst_n(rst_n), .adv(adv), .act(act), .hs(hs), .vs(vs),
    .fb_en(fb_en1), .fb_addr(fb_addr1), .fb_data(fb_data1), .rgb(rgb1),
    .hs_o(hs_o1), .vs_o(vs_o1), .de_o(de_o1),
    .frame_start(frame_start1), .line_err(line_err1)
  );

  vga_pixel_fetch #(.HACT(HACT), .VACT(VACT), .SCALE(2), .RD_LAT(3), .PIX_W(12)) u_s2 (
    .clk(clk), .rst_n(rst_n), .adv(adv), .act(act), .hs(hs), .vs(vs),
    .fb_en(fb_en2), .fb_addr(fb_addr2), .fb_data(fb_data2), .rgb(rgb2),
    .hs_o(hs_o2), .vs_o(vs_o2), .de_o(de_o2),
    .frame_start(frame_start2), .line_err(line_err2)
  );

  // ---------------- framebuffer RAM models ----------------
  logic [11:0] mem1 [HACT * VACT];
  logic [11:0] mem2 [(HACT / 2) * (VACT / 2)];
  logic [11:0] p1;
  logic [11:0] p2 [3];

  assign fb_data1 = p1;
  assign fb_data2 = p2[2];

  // Outside the valid cycle the RAM returns junk, so a mistimed capture shows.
  initial begin
    forever begin
      @(posedge clk);
      p1    <= fb_en1 ? mem1[fb_addr1] : 12'($urandom);
      p2[0] <= fb_en2 ? mem2[fb_addr2] : 12'($urandom);
      p2[1] <= p2[0];
      p2[2] <= p2[1];
    end
  end

  // ---------------- reference model ----------------
  logic [14:0] exp1_q[$];
  logic [14:0] exp2_q[$];
  int          ea1_q[$];
  int          ea2_q[$];

  bit          synced, m_act, m_hs, m_vs, m_de, err_exp;
  int          line, x;
  logic [11:0] hold1, hold2;
  int          n_reads1, n_reads2, last1, last2, fs1, fs2;

  function automatic int src_addr(input int sc, input int ln, input int px);
    int row;
    row = ln / sc;
    if (row > VACT / sc - 1) row = VACT / sc - 1;
    return row * (HACT / sc) + px / sc;
  endfunction

  task automatic model_reset();
    synced = 0; m_act = 0; m_hs = 0; m_vs = 0; m_de = 0; err_exp = 0;
    line = 0; x = 0; hold1 = '0; hold2 = '0;
    exp1_q.delete(); exp2_q.delete(); ea1_q.delete(); ea2_q.delete();
  endtask

  task automatic fill_mem();
    foreach (mem1[i]) mem1[i] = 12'($urandom_range(1, 4095));
    foreach (mem2[i]) mem2[i] = 12'($urandom_range(1, 4095));
  endtask

  // ---------------- driver ----------------
  // One pixel period: adv high for one clock, flags held for the period.
  task automatic pix(input bit a, input bit h, input bit v);
    bit cur_run, rise;
    int a1, a2;
    cur_run = synced;
    rise    = v && !m_vs;
    if (rise) begin
      line = 0; x = 0;
    end else if (cur_run && m_act && !a) begin
      if (x != HACT) err_exp = 1;
      line++; x = 0;
    end
    exp1_q.push_back({m_hs, m_vs, m_de, m_de ? hold1 : 12'h000});
    exp2_q.push_back({m_hs, m_vs, m_de, m_de ? hold2 : 12'h000});
    if (cur_run && a) begin
      if (x < HACT) begin
        a1 = src_addr(1, line, x);
        a2 = src_addr(2, line, x);
        ea1_q.push_back(a1);
        ea2_q.push_back(a2);
        hold1 = mem1[a1];
        hold2 = mem2[a2];
      end else begin
        err_exp = 1;
      end
      x++;
    end
    m_act = a; m_hs = h; m_vs = v; m_de = cur_run && a;
    if (rise) synced = 1;
    adv = 1'b1; act = a; hs = h; vs = v;
    @(posedge clk); #1;
    adv = 1'b0;
    repeat (ADV_GAP - 1) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic run_line(input int n_act, input bit v);
    for (int i = 0; i < n_act; i++) pix(1'b1, 1'b0, v);
    for (int i = 0; i < HBLANK; i++) pix(1'b0, (i >= 2 && i < 5), v);
  endtask

  task automatic frame(input int n_lines, input int short_ln);
    run_line(0, 1'b1);
    run_line(0, 1'b0);
    for (int l = 0; l < n_lines; l++) run_line((l == short_ln) ? HACT - 1 : HACT, 1'b0);
    run_line(0, 1'b0);
  endtask

  // ---------------- scoreboard / monitors ----------------
  initial begin : monitor
    bit          adv_prev;
    logic [14:0] ex;
    int          e;
    adv_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (adv_prev && rst_n) begin
        checks++;
        if (exp1_q.size() == 0) begin
          errors++;
          $display("FAIL out1: got %h, no expected entry", {hs_o1, vs_o1, de_o1, rgb1});
        end else begin
          ex = exp1_q.pop_front();
          if ({hs_o1, vs_o1, de_o1, rgb1} !== ex) begin
            errors++;
            $display("FAIL out1 {hs,vs,de,rgb}: got %h expected %h", {hs_o1, vs_o1, de_o1, rgb1}, ex);
          end
        end
        checks++;
        if (exp2_q.size() == 0) begin
          errors++;
          $display("FAIL out2: got %h, no expected entry", {hs_o2, vs_o2, de_o2, rgb2});
        end else begin
          ex = exp2_q.pop_front();
          if ({hs_o2, vs_o2, de_o2, rgb2} !== ex) begin
            errors++;
            $display("FAIL out2 {hs,vs,de,rgb}: got %h expected %h", {hs_o2, vs_o2, de_o2, rgb2}, ex);
          end
        end
      end
      adv_prev = adv;
      if (fb_en1) begin
        checks++; n_reads1++; last1 = int'(fb_addr1);
        if (ea1_q.size() == 0) begin
          errors++;
          $display("FAIL addr1: unexpected fb_en with addr %0d", fb_addr1);
        end else begin
          e = ea1_q.pop_front();
          if (fb_addr1 !== A1W'(e)) begin
            errors++;
            $display("FAIL addr1: got %0d expected %0d", fb_addr1, e);
          end
        end
      end
      if (fb_en2) begin
        checks++; n_reads2++; last2 = int'(fb_addr2);
        if (ea2_q.size() == 0) begin
          errors++;
          $display("FAIL addr2: unexpected fb_en with addr %0d", fb_addr2);
        end else begin
          e = ea2_q.pop_front();
          if (fb_addr2 !== A2W'(e)) begin
            errors++;
            $display("FAIL addr2: got %0d expected %0d", fb_addr2, e);
          end
        end
      end
      if (frame_start1) fs1++;
      if (frame_start2) fs2++;
    end
  end

  // ---------------- tests ----------------
  task automatic check_drained(input string tag);
    checks++;
    if (ea1_q.size() != 0 || ea2_q.size() != 0) begin
      errors++;
      $display("FAIL %s reads missing: got %0d/%0d pending, expected 0/0", tag, ea1_q.size(), ea2_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; adv = 1'b0; act = 1'b0; hs = 1'b0; vs = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({fb_en1, frame_start1, line_err1, hs_o1, vs_o1, de_o1} !== 6'b0) begin
      errors++;
      $display("FAIL reset flags1: got %b expected 000000", {fb_en1, frame_start1, line_err1, hs_o1, vs_o1, de_o1});
    end
    checks++;
    if ({fb_en2, frame_start2, line_err2, hs_o2, vs_o2, de_o2} !== 6'b0) begin
      errors++;
      $display("FAIL reset flags2: got %b expected 000000", {fb_en2, frame_start2, line_err2, hs_o2, vs_o2, de_o2});
    end
    checks++;
    if (rgb1 !== 12'h0 || rgb2 !== 12'h0 || fb_addr1 !== '0 || fb_addr2 !== '0) begin
      errors++;
      $display("FAIL reset data: got rgb %h/%h addr %0d/%0d expected all 0", rgb1, rgb2, fb_addr1, fb_addr2);
    end
    checks++;
    if (u_s1.state_q !== UNSYNC || u_s2.state_q !== UNSYNC) begin
      errors++;
      $display("FAIL reset state: got %0d/%0d expected UNSYNC", u_s1.state_q, u_s2.state_q);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_unsync();
    n_reads1 = 0; n_reads2 = 0; fs1 = 0; fs2 = 0;
    run_line(HACT, 1'b0);
    run_line(HACT, 1'b0);
    checks++;
    if (n_reads1 != 0 || n_reads2 != 0) begin
      errors++;
      $display("FAIL unsync reads: got %0d/%0d expected 0", n_reads1, n_reads2);
    end
    checks++;
    if (line_err1 !== 1'b0 || line_err2 !== 1'b0) begin
      errors++;
      $display("FAIL unsync line_err: got %b/%b expected 0", line_err1, line_err2);
    end
    run_line(0, 1'b1);
    run_line(0, 1'b0);
    checks++;
    if (fs1 != 1 || fs2 != 1) begin
      errors++;
      $display("FAIL frame_start cycles: got %0d/%0d expected 1", fs1, fs2);
    end
  endtask

  task automatic test_frame();
    fill_mem();
    n_reads1 = 0; n_reads2 = 0; fs1 = 0;
    frame(VACT, -1);
    check_drained("frame");
    checks++;
    if (n_reads1 != HACT * VACT || n_reads2 != HACT * VACT) begin
      errors++;
      $display("FAIL frame read count: got %0d/%0d expected %0d", n_reads1, n_reads2, HACT * VACT);
    end
    checks++;
    if (last1 != HACT * VACT - 1 || last2 != (HACT / 2) * (VACT / 2) - 1) begin
      errors++;
      $display("FAIL frame last addr: got %0d/%0d expected %0d/%0d", last1, last2,
               HACT * VACT - 1, (HACT / 2) * (VACT / 2) - 1);
    end
    checks++;
    if (line_err1 !== 1'b0 || line_err2 !== 1'b0 || fs1 != 1) begin
      errors++;
      $display("FAIL frame flags: got err %b/%b fs %0d expected 0/0 1", line_err1, line_err2, fs1);
    end
  endtask

  task automatic test_short_line();
    fill_mem();
    // One extra line beyond VACT exercises the last-line hold.
    frame(VACT + 1, $urandom_range(0, VACT - 1));
    check_drained("short");
    checks++;
    if (line_err1 !== err_exp || line_err2 !== err_exp || !err_exp) begin
      errors++;
      $display("FAIL short line_err: got %b/%b expected %b", line_err1, line_err2, err_exp);
    end
    frame(VACT, -1);
    check_drained("sticky");
    checks++;
    if (line_err1 !== 1'b1 || line_err2 !== 1'b1) begin
      errors++;
      $display("FAIL sticky line_err: got %b/%b expected 1", line_err1, line_err2);
    end
  endtask

  task automatic test_reset_mid_line();
    int k;
    k = $urandom_range(2, HACT - 3);
    run_line(0, 1'b1);
    run_line(0, 1'b0);
    run_line(HACT, 1'b0);
    for (int i = 0; i < k; i++) pix(1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({fb_en1, frame_start1, line_err1, hs_o1, vs_o1, de_o1, rgb1, fb_addr1} !== '0 ||
        {fb_en2, frame_start2, line_err2, hs_o2, vs_o2, de_o2, rgb2, fb_addr2} !== '0) begin
      errors++;
      $display("FAIL mid-line reset: got err %b/%b de %b/%b rgb %h/%h addr %0d/%0d expected all 0",
               line_err1, line_err2, de_o1, de_o2, rgb1, rgb2, fb_addr1, fb_addr2);
    end
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_reads1 = 0; n_reads2 = 0;
    for (int i = k; i < HACT; i++) pix(1'b1, 1'b0, 1'b0);
    run_line(HACT, 1'b0);
    checks++;
    if (n_reads1 != 0 || n_reads2 != 0) begin
      errors++;
      $display("FAIL post-reset reads before vs: got %0d/%0d expected 0", n_reads1, n_reads2);
    end
    fill_mem();
    frame(VACT, -1);
    check_drained("restart");
    checks++;
    if (n_reads1 != HACT * VACT || line_err1 !== 1'b0 || line_err2 !== 1'b0) begin
      errors++;
      $display("FAIL restart frame: got reads %0d err %b/%b expected %0d 0/0",
               n_reads1, line_err1, line_err2, HACT * VACT);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    n_reads1 = 0; n_reads2 = 0; last1 = 0; last2 = 0; fs1 = 0; fs2 = 0;
    fill_mem();
    test_reset();
    test_unsync();
    test_frame();
    test_short_line();
    test_reset_mid_line();
    repeat (4) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_pixel_fetch.md
# vga_pixel_fetch

Downstream neighbour of the VGA timing controller. Consumes its per-pixel strobes (`adv`, `act`, `hs`, `vs`) and generates framebuffer read addresses, with optional integer pixel/line replication. Captures the returned pixel data and drives the registered RGB output and sync pins, which are delayed to stay aligned with the data. Sits between the timing controller and the board's DAC/pins, with a synchronous-read framebuffer RAM on its side port.

## Interface
- `HACT`, 640: active pixels per line at the output.
- `VACT`, 480: active lines per frame at the output.
- `SCALE`, 1: replication factor applied to both axes. Legal values are 1, 2, 4. Source image is `HACT/SCALE` × `VACT/SCALE`.
- `RD_LAT`, 1: framebuffer read latency in `clk` cycles. Legal range 1..3, and it must be less than the `adv` spacing.
- `PIX_W`, 12: pixel width (RGB444).
- `ADDR_W`, `$clog2((HACT/SCALE)*(VACT/SCALE))`: framebuffer address width.
- `clk` in 1: system clock, the same clock as the timing controller.
- `rst_n` in 1: asynchronous, active-low reset.
- `adv` in 1: one-cycle pixel strobe. `act`/`hs`/`vs` are valid and sampled only on cycles with `adv`=1.
- `act` in 1: active-video flag from timing.
- `hs` in 1: horizontal sync from timing.
- `vs` in 1: vertical sync from timing.
- `fb_en` out 1: framebuffer read enable, one `clk` pulse.
- `fb_addr` out `ADDR_W`: framebuffer read address, valid when `fb_en`=1.
- `fb_data` in `PIX_W`: read data, valid exactly `RD_LAT` cycles after `fb_en`.
- `rgb` out `PIX_W`: pixel to the DAC. Zero whenever `de_o`=0.
- `hs_o` out 1: `hs` delayed one pixel period.
- `vs_o` out 1: `vs` delayed one pixel period.
- `de_o` out 1: `act` delayed one pixel period.
- `frame_start` out 1: one-cycle pulse on the rising edge of `vs`.
- `line_err` out 1: sticky flag set when an active line length is not equal to `HACT`.

## Operation
- **State `UNSYNC` (after reset):** no `fb_en`; `rgb`, `de_o` held at 0; `hs_o`/`vs_o` still follow the delayed inputs. On the first sampled `vs` rising edge, go to `RUN`.
- **`vs` rising edge (any state):** clear `line_base`, `addr`, `xsub`, `ysub`, `xcnt`; pulse `frame_start`.
- **`RUN`, `adv` with `act`=1:**
  - Assert `fb_en` with `fb_addr`=`addr` in the same cycle.
  - `xsub` increments. When `xsub` wraps at `SCALE`, `addr` increments.
  - `xcnt` counts pixels and saturates at `HACT`. A pixel beyond `HACT` still outputs but issues no `fb_en`, and sets `line_err`.
- **End of line** (sampled `act` 1→0):
  - If `xcnt`≠`HACT`, set `line_err`.
  - `ysub` increments. When it wraps at `SCALE`, `line_base` += `HACT/SCALE`; otherwise the source line repeats.
  - `addr` is set to the new `line_base`; `xsub`, `xcnt` are cleared.
- **Bounds:** `addr` never exceeds `(HACT/SCALE)*(VACT/SCALE)-1`. Extra lines beyond `VACT` hold `line_base` at the last line.
- **Capture:** a `RD_LAT`-deep valid shift register tracks `fb_en`. When it emerges, `fb_data` is loaded into `pix_hold`.
- **Output:** on each `adv`, register `rgb`=`de_d ? pix_hold : 0`. `hs_o`, `vs_o`, `de_o` are the values sampled on the previous `adv`.
- **Simultaneous `vs` rise and end-of-line:** `vs` clear wins.
- **Reset mid-frame:** all state returns to `UNSYNC` immediately.

## Timing
- **Reset values:** `fb_en`=0, `fb_addr`=0, `rgb`=0, `hs_o`=0, `vs_o`=0, `de_o`=0, `frame_start`=0, `line_err`=0. State is `UNSYNC`.
- **Latency:** pixel data at `rgb`, and the matching `de_o`/`hs_o`/`vs_o`, appear on the `clk` edge of the `adv` following the one that issued the read, i.e. one pixel period.
- **Output hold:** all outputs change only on `adv` cycles, except `fb_en`, `frame_start`, and `line_err`.
- **`fb_en`:** high for exactly one `clk` per active pixel.

## Structure
- Shared package `vga_pkg`: legal `SCALE` set check, `state_t` (`UNSYNC`, `RUN`), pixel type width constant.
- One sub-module `vga_fetch_delay`: the `RD_LAT` valid shift register plus the data capture register.
- Address/replication counters and output register stay in the top.

## Test plan
- **Reset/UNSYNC:** drive timing with `act` pulses before any `vs` → zero `fb_en`, `rgb`=0. After the first `vs` rise → `frame_start`=1 for one cycle, then reads begin.
- **`SCALE`=1, 640×480 frame:** `fb_addr` runs 0..307199 in order. Line 1 starts at 640. `rgb` equals RAM contents one pixel period after each read; `de_o` aligns with nonzero `rgb`.
- **`SCALE`=2:** addresses go 0,0,1,1,…,319,319 on line 0 and repeat identically on line 1. Line 2 starts at 320; the last line's final address is 76799.
- **Short line (639 active pixels):** `line_err` rises at end of line and stays 1 across frames until `rst_n` is asserted. The next line still starts at the correct `line_base`.
- **`RD_LAT`=3 with `adv` every 4 clocks:** `rgb` is still correct and aligned. `hs_o`/`vs_o` lag `hs`/`vs` by exactly one `adv` period.
- **`rst_n` pulse mid-line:** all outputs are 0 immediately. There is no `fb_en` until the next `vs` rise, after which `fb_addr` restarts at 0.
